// File: rtl/line_echo_responder.sv
// line_echo_responder: reads a console line, echoes it back upper-cased, then signals completion
module line_echo_responder #(
    parameter int BUFFER_LEN = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        out_newASCII_ready,
    input  logic [12:0] out_lineLen,
    input  logic [7:0]  lineOut,
    output logic        lineOut_nextASCII,
    output logic        in_newASCII_ready,
    output logic [7:0]  lineIn,
    input  logic        lineIn_nextASCII,
    output logic        in_solved,
    input  logic        out_solved,
    output logic        busy
);
    localparam int AW = BUFFER_LEN > 1 ? $clog2(BUFFER_LEN) : 1;
    localparam logic [12:0] MAX_LEN = 13'(BUFFER_LEN);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] READ     = 3'd1;
    localparam logic [2:0] DRAIN    = 3'd2;
    localparam logic [2:0] WRITE    = 3'd3;
    localparam logic [2:0] TERM     = 3'd4;
    localparam logic [2:0] SOLVE    = 3'd5;
    localparam logic [2:0] WAIT_ACK = 3'd6;

    logic [2:0]  state;
    logic [7:0]  len;
    logic [7:0]  rd_cnt;
    logic [7:0]  wr_cnt;
    logic [12:0] sur_cnt;
    logic [7:0]  line_buf [BUFFER_LEN];
    logic [7:0]  cur;
    logic        capture;

    assign capture = state == READ && rd_cnt < len && !lineOut_nextASCII;
    assign cur = line_buf[wr_cnt[AW-1:0]];

    // Outputs are decoded from state so reset clears them immediately
    always_comb begin
        in_newASCII_ready = state == WRITE || state == TERM;
        lineIn = state == WRITE ? ((cur >= 8'h61 && cur <= 8'h7a) ? cur - 8'h20 : cur) : 8'h00;
        in_solved = state == SOLVE;
        busy = state != IDLE;
    end

    // Line storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (capture) line_buf[rd_cnt[AW-1:0]] <= lineOut;
    end

    // Main FSM; surplus characters beyond the buffer are acknowledged and dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len <= 8'd0;
            rd_cnt <= 8'd0;
            wr_cnt <= 8'd0;
            sur_cnt <= 13'd0;
            lineOut_nextASCII <= 1'b0;
        end else begin
            lineOut_nextASCII <= 1'b0;
            case (state)
                IDLE: if (out_newASCII_ready) begin
                    len <= out_lineLen > MAX_LEN ? MAX_LEN[7:0] : out_lineLen[7:0];
                    sur_cnt <= out_lineLen > MAX_LEN ? out_lineLen - MAX_LEN : 13'd0;
                    rd_cnt <= 8'd0;
                    state <= READ;
                end
                READ: if (rd_cnt < len) begin
                    if (!lineOut_nextASCII) begin
                        rd_cnt <= rd_cnt + 8'd1;
                        lineOut_nextASCII <= 1'b1;
                    end
                end else if (sur_cnt != 13'd0) begin
                    if (!lineOut_nextASCII) begin
                        sur_cnt <= sur_cnt - 13'd1;
                        lineOut_nextASCII <= 1'b1;
                    end
                end else begin
                    state <= DRAIN;
                end
                DRAIN: if (!out_newASCII_ready) begin
                    state <= len == 8'd0 ? SOLVE : WRITE;
                    wr_cnt <= 8'd0;
                end
                WRITE: if (lineIn_nextASCII) begin
                    if (wr_cnt == len - 8'd1) state <= TERM;
                    else wr_cnt <= wr_cnt + 8'd1;
                end
                TERM: if (lineIn_nextASCII) state <= SOLVE;
                SOLVE: state <= WAIT_ACK;
                WAIT_ACK: if (out_solved) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_echo_responder.sv
// tb_line_echo_responder: console model with scoreboard of expected echoed bytes
module tb_line_echo_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_newASCII_ready = 1'b0;
    logic [12:0] out_lineLen = 13'd0;
    logic [7:0]  lineOut = 8'h00;
    logic        lineOut_nextASCII;
    logic        in_newASCII_ready;
    logic [7:0]  lineIn;
    logic        lineIn_nextASCII = 1'b0;
    logic        in_solved;
    logic        out_solved = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];

    typedef struct {
        string text;
        int    len;
        int    stall_at;
        int    stall_cyc;
        int    ack_delay;
        int    abort_at;
    } vec_t;

    vec_t vecs[8];

    line_echo_responder #(.BUFFER_LEN(128)) dut (
        .clk(clk),
        .rst(rst),
        .out_newASCII_ready(out_newASCII_ready),
        .out_lineLen(out_lineLen),
        .lineOut(lineOut),
        .lineOut_nextASCII(lineOut_nextASCII),
        .in_newASCII_ready(in_newASCII_ready),
        .lineIn(lineIn),
        .lineIn_nextASCII(lineIn_nextASCII),
        .in_solved(in_solved),
        .out_solved(out_solved),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] chr(string t, int i);
        if (i < t.len()) return t[i];
        return 8'(32 + (i * 7) % 95);
    endfunction

    function automatic logic [7:0] up(logic [7:0] c);
        if (c inside {[8'h61:8'h7a]}) return c & 8'hdf;
        return c;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_line(vec_t v);
        int pulses = 0;
        int wcount = 0;
        int solved = 0;
        int hold = 0;
        int stall_bad = 0;
        int busy_bad = 0;
        int cyc = 0;
        int acked = 0;
        int ackwait = 0;
        int post = 0;
        int exp_w;
        bit got = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] e;
        exp_w = v.len > 128 ? 128 : v.len;
        q.delete();
        for (int i = 0; i < exp_w; i++) q.push_back(up(chr(v.text, i)));
        if (v.len > 0) q.push_back(8'h00);
        @(negedge clk);
        out_lineLen = 13'(v.len);
        lineOut = v.len > 0 ? chr(v.text, 0) : 8'h00;
        out_newASCII_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                check("timeout", 1, 0);
                break;
            end
            if (lineOut_nextASCII) begin
                pulses++;
                lineOut = pulses < v.len ? chr(v.text, pulses) : 8'h00;
            end
            if (out_newASCII_ready && busy && pulses == v.len) begin
                out_newASCII_ready = 1'b0;
                lineOut = 8'h00;
            end
            if (in_solved) solved++;
            if (v.abort_at >= 0 && in_newASCII_ready && !got && !lineIn_nextASCII && wcount == v.abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check("rst_outputs", int'({lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved, busy}), 0);
                @(negedge clk);
                rst = 1'b0;
                out_newASCII_ready = 1'b0;
                lineIn_nextASCII = 1'b0;
                lineOut = 8'h00;
                q.delete();
                return;
            end
            if (lineIn_nextASCII) begin
                lineIn_nextASCII = 1'b0;
                got = 0;
            end else if (in_newASCII_ready) begin
                if (!got) begin
                    if (q.size() == 0) check("extra_char", int'(lineIn), -1);
                    else begin
                        e = q.pop_front();
                        check($sformatf("char%0d", wcount), int'(lineIn), int'(e));
                    end
                    got = 1;
                    held = lineIn;
                    hold = wcount == v.stall_at ? v.stall_cyc : 0;
                    wcount++;
                end else if (lineIn != held) stall_bad++;
                if (hold == 0) lineIn_nextASCII = 1'b1;
                else hold--;
            end else if (got) stall_bad++;
            if (acked == 0 && solved > 0) begin
                if (ackwait < v.ack_delay) begin
                    if (!busy) busy_bad++;
                    ackwait++;
                end else begin
                    out_solved = 1'b1;
                    acked = 1;
                end
            end else if (acked == 1) begin
                if (!busy) begin
                    out_solved = 1'b0;
                    acked = 2;
                end
            end else if (acked == 2) begin
                if (busy) busy_bad++;
                post++;
                if (post == 3) break;
            end
        end
        check("read_pulses", pulses, v.len);
        check("solved_pulses", solved, 1);
        check("written", wcount, v.len > 0 ? exp_w + 1 : 0);
        check("leftover", q.size(), 0);
        check("stall_stable", stall_bad, 0);
        check("busy_wait", busy_bad, 0);
        check("busy_end", int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{"ab1", 3, -1, 0, 0, -1};
        vecs[1] = '{"", 0, -1, 0, 0, -1};
        vecs[2] = '{"", 200, -1, 0, 0, -1};
        vecs[3] = '{"hello", 5, 2, 4000, 0, -1};
        vecs[4] = '{"q!", 2, -1, 0, 100, -1};
        vecs[5] = '{"`az{@[", 6, -1, 0, 3, -1};
        vecs[6] = '{"", 128, -1, 0, 0, -1};
        vecs[7] = '{"", 129, -1, 0, 1, -1};
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(in_newASCII_ready), 0);
        check("rst_ack", int'(lineOut_nextASCII), 0);
        check("rst_lineIn", int'(lineIn), 0);
        check("rst_solved", int'(in_solved), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) run_line(vecs[i]);
        run_line('{"abcdefghij", 10, -1, 0, 0, 5});
        check("after_rst_idle", int'(busy), 0);
        run_line('{"x", 1, -1, 0, 0, -1});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
